// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control/status bundle between the multi-cycle sequencer and the 16-bit datapath
interface multicycle_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             run;
   logic [3:0]       opcode;
   logic             mem_ready;
   logic             pc_write;
   logic             ir_write;
   logic             jump;
   logic             beq;
   logic             bne;
   logic             mem_read;
   logic             mem_write;
   logic             alu_src;
   logic             reg_dst;
   logic             mem_to_reg;
   logic             reg_write;
   logic [1:0]       alu_op;
   logic [2:0]       state;
   logic             busy;
   logic             illegal_op;
   logic             mem_fault;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  run, opcode, mem_ready,
      output pc_write, ir_write, jump, beq, bne, mem_read, mem_write,
             alu_src, reg_dst, mem_to_reg, reg_write, alu_op,
             state, busy, illegal_op, mem_fault, instr_count
   );

   modport slave (
      output run, opcode, mem_ready,
      input  pc_write, ir_write, jump, beq, bne, mem_read, mem_write,
             alu_src, reg_dst, mem_to_reg, reg_write, alu_op,
             state, busy, illegal_op, mem_fault, instr_count
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer driving the 16-bit datapath controls from the returned opcode
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input logic               clk,
   input logic               reset,
   multicycle_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      FAULT  = 3'd6
   } state_t;

   state_t           state_q;
   state_t           end_d;
   logic [3:0]       op_q;
   logic [7:0]       wait_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ill_q;
   logic             fault_q;
   logic             op_lw, op_sw, op_r, op_beq, op_bne, op_j, op_mem, op_br;
   logic             dec_ill;
   logic             s_fetch, s_dec, s_exec, s_mem, s_wb;
   logic [1:0]       alu_cls;
   logic             pc_w;

   // classify the latched instruction, the live opcode (DECODE only) and the current state
   always_comb begin
      op_lw   = op_q == 4'd0;
      op_sw   = op_q == 4'd1;
      op_r    = op_q >= 4'd2 && op_q <= 4'd9;
      op_beq  = op_q == 4'd11;
      op_bne  = op_q == 4'd12;
      op_j    = op_q == 4'd13;
      op_mem  = op_lw | op_sw;
      op_br   = op_beq | op_bne | op_j;
      dec_ill = bus.opcode == 4'd10 || bus.opcode >= 4'd14;
      s_fetch = state_q == FETCH;
      s_dec   = state_q == DECODE;
      s_exec  = state_q == EXEC;
      s_mem   = state_q == MEM;
      s_wb    = state_q == WB;
      alu_cls = op_mem ? 2'b10 : (op_beq | op_bne) ? 2'b01 : 2'b00;
      end_d   = bus.run ? FETCH : IDLE;
      pc_w    = (s_dec & dec_ill) | (s_exec & op_br) | (s_mem & op_sw & bus.mem_ready) | s_wb;
   end

   // datapath controls decoded from state and latched opcode; IDLE and FAULT decode to all zero
   always_comb begin
      bus.pc_write    = pc_w;
      bus.ir_write    = s_fetch;
      bus.jump        = s_exec & op_j;
      bus.beq         = s_exec & op_beq;
      bus.bne         = s_exec & op_bne;
      bus.mem_read    = (s_mem | s_wb) & op_lw;
      bus.mem_write   = s_mem & op_sw;
      bus.alu_src     = (s_exec | s_mem) & op_mem;
      bus.reg_dst     = (s_exec | s_wb) & op_r;
      bus.mem_to_reg  = s_wb & op_lw;
      bus.reg_write   = s_wb;
      bus.alu_op      = (s_exec | s_mem | (s_wb & op_r)) ? alu_cls : 2'b00;
      bus.state       = state_q;
      bus.busy        = state_q != IDLE && state_q != FAULT;
      bus.illegal_op  = ill_q;
      bus.mem_fault   = fault_q;
      bus.instr_count = cnt_q;
   end

   // sequencer: state walk, opcode latch, memory wait timer, retired counter and sticky flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= 4'd0;
         wait_q  <= 8'd0;
         cnt_q   <= '0;
         ill_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         if (pc_w) cnt_q <= cnt_q + CNT_W'(1);
         case (state_q)
            IDLE:    if (bus.run) state_q <= FETCH;
            FETCH:   state_q <= DECODE;
            DECODE: begin
               op_q <= bus.opcode;
               if (dec_ill) ill_q <= 1'b1;
               state_q <= dec_ill ? end_d : EXEC;
            end
            EXEC:    state_q <= op_br ? end_d : op_mem ? MEM : WB;
            MEM: begin
               if (bus.mem_ready) begin
                  wait_q  <= 8'd0;
                  state_q <= op_lw ? WB : end_d;
               end else if (wait_q == 8'(MEM_TIMEOUT - 1)) begin
                  wait_q  <= 8'd0;
                  fault_q <= 1'b1;
                  state_q <= FAULT;
               end else begin
                  wait_q <= wait_q + 8'd1;
               end
            end
            WB:      state_q <= end_d;
            default: state_q <= FAULT;
         endcase
      end
   end
endmodule
